// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 size codes,
// access-unit FSM encoding and timeout counter width.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int TO_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Unused funct3 codes (011/110/111) quietly behave as word accesses.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated data for stores,
// byte/half extraction plus sign/zero extension for loads.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_uns;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        be    = 4'hF;
        wdata = st_data;
        if (is_store) begin
            case (f3_size(st_funct3))
                SZ_BYTE: begin
                    be    = 4'b0001 << st_addr_lo;
                    wdata = {4{st_data[7:0]}};
                end
                SZ_HALF: begin
                    be    = 4'b0011 << st_addr_lo;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    be    = 4'hF;
                    wdata = st_data;
                end
            endcase
        end
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_uns  = f3_unsigned(ld_funct3);

        ld_data = ld_word;
        case (f3_size(ld_funct3))
            SZ_BYTE: ld_data = ld_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data access unit with req/ack SRAM handshake, stall and timeout.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module dmem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err,
    output logic        misalign_err
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [2:0]          f3_q;
    logic [1:0]          addr_lo_q;
    logic                is_load_q;

    logic                access;
    logic [31:0]         addr_eff;
    logic [3:0]          st_be;
    logic [31:0]         st_wdata;
    logic [31:0]         ld_data;

    assign access = MemReadM | MemWriteM;

    // Low address bits below the access size are dropped so the lanes stay aligned.
    always_comb begin
        addr_eff = ALUResultM;
        case (f3_size(funct3M))
            SZ_HALF: addr_eff[0]   = 1'b0;
            SZ_WORD: addr_eff[1:0] = 2'b00;
            default: addr_eff      = ALUResultM;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    always_comb begin
        case (f3_size(funct3M))
            SZ_HALF: misaligned = ALUResultM[0];
            SZ_WORD: misaligned = |ALUResultM[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Stall starts in the IDLE cycle the access appears, without waiting for a clock.
    assign StallM = rst && (((state == ST_IDLE) && access) || (state == ST_REQ));

    dmem_lane_align u_lane_align (
        .is_store   (MemWriteM),
        .st_funct3  (funct3M),
        .st_addr_lo (addr_eff[1:0]),
        .st_data    (WriteDataM),
        .be         (st_be),
        .wdata      (st_wdata),
        .ld_funct3  (f3_q),
        .ld_addr_lo (addr_lo_q),
        .ld_word    (mem_rdata),
        .ld_data    (ld_data)
    );

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            f3_q        <= '0;
            addr_lo_q   <= '0;
            is_load_q   <= 1'b0;
            ReadDataM   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            timeout_err <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            timeout_err <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        f3_q      <= funct3M;
                        addr_lo_q <= addr_eff[1:0];
                        is_load_q <= ~MemWriteM;
                        to_cnt    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                            ReadDataM  <= '0;
                            state      <= ST_DONE;
                        end else
`endif
                        begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWriteM;
                            mem_addr  <= {addr_eff[31:2], 2'b00};
                            mem_wdata <= st_wdata;
                            mem_be    <= st_be;
                            state     <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        ReadDataM <= is_load_q ? ld_data : '0;
                        state     <= ST_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        mem_req     <= 1'b0;
                        ReadDataM   <= '0;
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: driver queues expected requests/responses,
// a negedge monitor compares them when the DUT issues a request or finishes an access.
module tb_dmem_access_unit;

    localparam int TMO = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        tmo;
        logic        mis;
        int          stall_n;
        int          req_n;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        timeout_err;
    logic        misalign_err;

    int          checks;
    int          errors;
    int          ack_at_g;
    logic [31:0] mem_word;
    string       cur_tag;
    req_t        req_q[$];
    rsp_t        rsp_q[$];

    dmem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .funct3M      (funct3M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .ReadDataM    (ReadDataM),
        .StallM       (StallM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .timeout_err  (timeout_err),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks in the ack_at_g-th REQ cycle (0 = never).
    initial begin
        int n;
        mem_ack = 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !mem_req) begin
                n = 0;
                mem_ack = 1'b0;
            end else begin
                n++;
                mem_ack = (n == ack_at_g);
            end
        end
    end

    // Monitor: checks requests when mem_req rises and responses on the cycle StallM falls.
    initial begin
        logic prev_req;
        logic prev_stall;
        logic pulse_chk;
        int   stall_n;
        int   req_n;
        req_t cur;
        req_t r;
        rsp_t s;
        prev_req = 1'b0;
        prev_stall = 1'b0;
        pulse_chk = 1'b0;
        stall_n = 0;
        req_n = 0;
        cur = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
                prev_stall = 1'b0;
                pulse_chk = 1'b0;
                stall_n = 0;
                req_n = 0;
            end else begin
                if (pulse_chk) begin
                    check({cur_tag, "_tmo_pulse_clear"}, 32'(timeout_err), 32'h0);
                    check({cur_tag, "_mis_pulse_clear"}, 32'(misalign_err), 32'h0);
                    pulse_chk = 1'b0;
                end
                if (StallM) stall_n++;
                if (mem_req) begin
                    req_n++;
                    if (!prev_req) begin
                        if (req_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL %s_req: unexpected request to 0x%08h, none expected", cur_tag, mem_addr);
                        end else begin
                            r = req_q.pop_front();
                            cur = r;
                            check({cur_tag, "_we"}, 32'(mem_we), 32'(r.we));
                            check({cur_tag, "_addr"}, mem_addr, r.addr);
                            check({cur_tag, "_be"}, 32'(mem_be), 32'(r.be));
                            if (r.we) check({cur_tag, "_wdata"}, mem_wdata, r.wdata);
                        end
                    end else begin
                        check({cur_tag, "_addr_stable"}, mem_addr, cur.addr);
                        check({cur_tag, "_be_stable"}, 32'(mem_be), 32'(cur.be));
                    end
                end
                if (prev_stall && !StallM) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s_rsp: unexpected completion, none expected", cur_tag);
                    end else begin
                        s = rsp_q.pop_front();
                        if (s.chk_rdata) check({cur_tag, "_rdata"}, ReadDataM, s.rdata);
                        check({cur_tag, "_timeout_err"}, 32'(timeout_err), 32'(s.tmo));
                        check({cur_tag, "_misalign_err"}, 32'(misalign_err), 32'(s.mis));
                        check({cur_tag, "_stall_cycles"}, 32'(stall_n), 32'(s.stall_n));
                        check({cur_tag, "_req_cycles"}, 32'(req_n), 32'(s.req_n));
                    end
                    stall_n = 0;
                    req_n = 0;
                    pulse_chk = 1'b1;
                end
                prev_req = mem_req;
                prev_stall = StallM;
            end
        end
    end

    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] word, input logic issue,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic exp_tmo, input logic exp_mis);
        req_t r;
        rsp_t s;
        int   n;
        ack_at_g = ack_at;
        mem_word = word;
        cur_tag  = tag;
        if (issue) begin
            r.we    = wr;
            r.addr  = {addr[31:2], 2'b00};
            r.be    = exp_be;
            r.wdata = exp_wdata;
            req_q.push_back(r);
        end
        s.chk_rdata = rd & ~wr;
        s.rdata     = exp_rdata;
        s.tmo       = exp_tmo;
        s.mis       = exp_mis;
        s.req_n     = issue ? ((ack_at == 0) ? TMO : ack_at) : 0;
        s.stall_n   = 1 + s.req_n;
        rsp_q.push_back(s);

        @(posedge clk);
        #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (StallM && n < 40);
        if (StallM) begin
            checks++;
            errors++;
            $display("FAIL %s_done: StallM still 1 after %0d cycles, expected 0", tag, n);
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_t r;
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = 3'b010;
        ALUResultM = 32'h100;
        WriteDataM = 32'h0;
        ack_at_g   = 0;
        mem_word   = 32'h0;
        cur_tag    = "reset";

        // Reset state, with a load request present to show StallM is held low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_StallM", 32'(StallM), 32'h0);
        check("reset_mem_req", 32'(mem_req), 32'h0);
        check("reset_mem_we", 32'(mem_we), 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_be", 32'(mem_be), 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_ReadDataM", ReadDataM, 32'h0);
        check("reset_timeout_err", 32'(timeout_err), 32'h0);
        check("reset_misalign_err", 32'(misalign_err), 32'h0);
        MemReadM = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;

        // tag, rd, wr, f3, addr, wdata, ack_at, mem word, issue, be, wdata, rdata, tmo, mis
        run_access("sw_ack3",  0, 1, 3'b010, 32'h100, 32'h11223344, 3, 32'h0,        1, 4'hF,    32'h11223344, 32'h0,        0, 0);
        run_access("lb_203",   1, 0, 3'b000, 32'h203, 32'h0,        1, 32'h80FF7F01, 1, 4'hF,    32'h0,        32'hFFFFFF80, 0, 0);
        run_access("lbu_203",  1, 0, 3'b100, 32'h203, 32'h0,        1, 32'h80FF7F01, 1, 4'hF,    32'h0,        32'h00000080, 0, 0);
        run_access("lh_202",   1, 0, 3'b001, 32'h202, 32'h0,        2, 32'h80FF7F01, 1, 4'hF,    32'h0,        32'hFFFF80FF, 0, 0);
        run_access("lhu_200",  1, 0, 3'b101, 32'h200, 32'h0,        1, 32'h80FF7F01, 1, 4'hF,    32'h0,        32'h00007F01, 0, 0);
        run_access("lw_200",   1, 0, 3'b010, 32'h200, 32'h0,        1, 32'h80FF7F01, 1, 4'hF,    32'h0,        32'h80FF7F01, 0, 0);
        run_access("sb_102",   0, 1, 3'b000, 32'h102, 32'h000000AB, 1, 32'h0,        1, 4'b0100, 32'hABABABAB, 32'h0,        0, 0);
        run_access("sh_106",   0, 1, 3'b001, 32'h106, 32'h1234CDEF, 2, 32'h0,        1, 4'b1100, 32'hCDEFCDEF, 32'h0,        0, 0);
        run_access("sw_f3_111",0, 1, 3'b111, 32'h108, 32'hDEADBEEF, 1, 32'h0,        1, 4'hF,    32'hDEADBEEF, 32'h0,        0, 0);
        run_access("lw_f3_011",1, 0, 3'b011, 32'h10C, 32'h0,        1, 32'h0BADCAFE, 1, 4'hF,    32'h0,        32'h0BADCAFE, 0, 0);
        run_access("rw_both",  1, 1, 3'b010, 32'h110, 32'h55AA55AA, 1, 32'h0,        1, 4'hF,    32'h55AA55AA, 32'h0,        0, 0);
        run_access("lw_tmo",   1, 0, 3'b010, 32'h300, 32'h0,        0, 32'h12345678, 1, 4'hF,    32'h0,        32'h00000000, 1, 0);
        run_access("lw_ack8",  1, 0, 3'b010, 32'h304, 32'h0,        8, 32'hCAFEF00D, 1, 4'hF,    32'h0,        32'hCAFEF00D, 0, 0);

        // Reset in the middle of a request: mem_req and StallM must drop without a clock.
        cur_tag  = "rst_mid";
        ack_at_g = 0;
        r = '{we: 1'b0, addr: 32'h400, be: 4'hF, wdata: 32'h0};
        req_q.push_back(r);
        @(posedge clk);
        #1;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = 3'b010;
        ALUResultM = 32'h400;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check("rst_mid_StallM", 32'(StallM), 32'h0);
        MemReadM = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_access("lw_after_rst", 1, 0, 3'b010, 32'h400, 32'h0, 2, 32'h13572468, 1, 4'hF, 32'h0, 32'h13572468, 0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
        run_access("lw_102_trap",  1, 0, 3'b010, 32'h102, 32'h0, 1, 32'hA5A50F0F, 0, 4'hF, 32'h0, 32'h00000000, 0, 1);
        run_access("lhu_203_trap", 1, 0, 3'b101, 32'h203, 32'h0, 1, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'h00000000, 0, 1);
`else
        run_access("lw_102_align", 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'hA5A50F0F, 1, 4'hF, 32'h0, 32'hA5A50F0F, 0, 0);
        run_access("lhu_203_align",1, 0, 3'b101, 32'h203, 32'h0, 1, 32'h80FF7F01, 1, 4'hF, 32'h0, 32'h000080FF, 0, 0);
`endif

        repeat (3) @(posedge clk);
        check("req_queue_drained", 32'(req_q.size()), 32'h0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
